load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential RV32IM load/store unit between the execute stage and `data_memory`. It accepts one load or store request at a time and checks its range and encoding. It drives `data_memory`'s byte-addressed port, and returns a sign- or zero-extended load result or a store completion. Naturally aligned accesses take one memory cycle. Misaligned halfword/word accesses are split into sequential byte accesses, so `data_memory` only ever sees aligned or byte traffic.

## Interface
- `MEM_BYTES`, 1024: size of the data memory in bytes; legal byte addresses are 0..MEM_BYTES-1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_is_load` in 1: request is a load.
- `req_is_store` in 1: request is a store.
- `req_funct3` in 3: RV32 funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in 32: byte address, already computed rs1+imm.
- `req_wdata` in 32: store data (rs2).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; request was rejected.
- `mem_read`, `mem_write` out 1: to `data_memory`.
- `mem_size` out 2: 00 byte, 01 half, 10 word.
- `mem_addr` out 32: byte address to `data_memory`.
- `mem_wdata` out 32: write data to `data_memory`.
- `mem_rdata` in 32: combinational read data from `data_memory`, zero-extended by size.

## Operation
- FSM states: IDLE, ACCESS, SPLIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch addr, wdata, funct3, and direction.
  - Width n = 1/2/4 bytes, from funct3[1:0].
  - Error if any of: load and store both set or both clear; illegal funct3; addr+n-1 ≥ MEM_BYTES. Compute the range check in 33 bits, so an address near 2^32 with no wrap is still an error.
  - Error → RESP with err=1; no memory strobe is ever asserted.
  - Legal and addr aligned to n → ACCESS.
  - Legal and misaligned → SPLIT with byte index k=0.
- **ACCESS**
  - Drive `mem_size`=n encoding, `mem_addr`=addr, `mem_wdata`=wdata, and `mem_read` or `mem_write` for exactly one cycle.
  - Load data is captured from `mem_rdata` at the closing edge.
  - → RESP.
- **SPLIT**
  - Each cycle: `mem_size`=00, `mem_addr`=addr+k, `mem_wdata`={24'b0, wdata byte k}.
  - Load byte k is captured into result byte lane k.
  - k increments; after k=n-1 → RESP.
- **RESP**
  - `resp_valid`=1.
  - `resp_rdata`: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW passes through.
  - → IDLE.
- Outside ACCESS/SPLIT, all `mem_*` outputs are 0.
- `resp_rdata` and `resp_err` are 0 whenever `resp_valid`=0.
- Reset mid-operation: the FSM returns to IDLE at once and the pending request is dropped. Bytes already written stay written; no further writes occur.

## Timing
- Reset values:
  - `req_ready`=1 during and after reset.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - All `mem_*` outputs = 0.
  - State = IDLE, k=0.
- Acceptance edge is T (`req_valid`&&`req_ready`). Latency:
  - Aligned access: memory cycle T+1, `resp_valid` at T+2.
  - Misaligned half: byte cycles T+1..T+2, response T+3.
  - Misaligned word: byte cycles T+1..T+4, response T+5.
  - Error: response T+1.
- `req_ready` is low from T+1 through the RESP cycle. The next request is accepted no earlier than the cycle after RESP, so maximum throughput is one request per 3 cycles.
- Stores commit at the rising edge ending each ACCESS/SPLIT cycle.

## Structure
- Package `lsu_pkg`:
  - state enum.
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - `mem_size` encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
- Sub-module `lsu_load_extend`: purely combinational; takes funct3 and the raw 32-bit result and produces the extended result. It is instantiated at the output.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → one write cycle with size 10; load `resp_valid` at T+2 with `resp_rdata`=0xDEADBEEF, err=0.
- After the above: LB @0x11 → 0xFFFFFFBE; LBU @0x11 → 0x000000BE; LH @0x12 → 0xFFFFDEAD; LHU @0x12 → 0x0000DEAD.
- SW 0x11223344 @0x21 → byte writes 0x44,0x33,0x22,0x11 to 0x21..0x24 on T+1..T+4, response T+5. LW @0x21 → 0x11223344 at T+5.
- LH @0x3FF (MEM_BYTES=1024) and load funct3=3 @0x0 → `resp_err`=1 at T+1, `mem_read`/`mem_write` never asserted, `resp_rdata`=0.
- Misaligned SW 0xAABBCCDD @0x41 with `rst_n` pulsed low during the third byte cycle → all outputs 0 immediately. 0x41=0xDD and 0x42=0xCC are written; 0x43/0x44 are unchanged. `req_ready`=1 after release.
- `req_valid` held high with two back-to-back LWs → second accepted exactly one cycle after the first `resp_valid`, never earlier.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// Imported by the LSU datapath and its load-extension helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_SPLIT,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of raw load data by RV32 funct3.
// Purely combinational.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            F3_B:    data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_BU:   data_o = {24'b0, raw_i[7:0]};
            F3_HU:   data_o = {16'b0, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequential RV32 load/store unit; misaligned half/word
// accesses are split into byte accesses to data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q;
    logic [1:0]  k_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic        err_q;
    logic [31:0] raw_q;

    logic [1:0]  nm1;
    logic        f3_ok;
    logic        dir_ok;
    logic [32:0] last_byte;
    logic        req_bad;
    logic        aligned;
    logic [31:0] ext_data;

    always_comb begin
        nm1 = 2'd0;
        case (req_funct3[1:0])
            2'd1:    nm1 = 2'd1;
            2'd2:    nm1 = 2'd3;
            default: nm1 = 2'd0;
        endcase
        f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H)
             || (req_funct3 == F3_W);
        if (req_is_load)
            f3_ok = f3_ok || (req_funct3 == F3_BU)
                 || (req_funct3 == F3_HU);
        dir_ok = req_is_load ^ req_is_store;
        // 33-bit sum so an access running past 2^32 is caught, not wrapped
        last_byte = {1'b0, req_addr} + {31'b0, nm1};
        req_bad = !dir_ok || !f3_ok || (last_byte >= 33'(MEM_BYTES));
        aligned = (req_addr[1:0] & nm1) == 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            raw_q   <= 32'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        f3_q    <= req_funct3;
                        load_q  <= req_is_load;
                        err_q   <= req_bad;
                        raw_q   <= 32'd0;
                        k_q     <= 2'd0;
                        if (req_bad)
                            state_q <= S_RESP;
                        else if (aligned)
                            state_q <= S_ACCESS;
                        else
                            state_q <= S_SPLIT;
                    end
                end
                S_ACCESS: begin
                    if (load_q)
                        raw_q <= mem_rdata;
                    state_q <= S_RESP;
                end
                S_SPLIT: begin
                    if (load_q)
                        raw_q[{k_q, 3'b000} +: 8] <= mem_rdata[7:0];
                    if (k_q == (f3_q[1] ? 2'd3 : 2'd1)) begin
                        k_q     <= 2'd0;
                        state_q <= S_RESP;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    lsu_load_extend u_ext (
        .funct3_i (f3_q),
        .raw_i    (raw_q),
        .data_o   (ext_data)
    );

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && load_q && !err_q) ? ext_data : 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = SZ_BYTE;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        if (state_q == S_ACCESS) begin
            mem_read  = load_q;
            mem_write = !load_q;
            mem_size  = f3_q[1:0];
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end else if (state_q == S_SPLIT) begin
            mem_read  = load_q;
            mem_write = !load_q;
            mem_addr  = addr_q + {30'b0, k_q};
            mem_wdata = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_is_load, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [7:0] mem [0:1023];
    logic [9:0] ma;
    assign ma = mem_addr[9:0];

    always_comb begin
        mem_rdata = {24'b0, mem[ma]};
        if (mem_size == 2'b01)
            mem_rdata = {16'b0, mem[ma + 10'd1], mem[ma]};
        else if (mem_size == 2'b10)
            mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2],
                         mem[ma + 10'd1], mem[ma]};
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[ma] <= mem_wdata[7:0];
            if (mem_size != 2'b00) mem[ma + 10'd1] <= mem_wdata[15:8];
            if (mem_size == 2'b10) begin
                mem[ma + 10'd2] <= mem_wdata[23:16];
                mem[ma + 10'd3] <= mem_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } rexp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          cyc;
    } wexp_t;

    rexp_t rq[$];
    wexp_t wq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Response and memory-strobe monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected resp", 32'd1, 32'd0);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    check({e.name, " rdata"}, resp_rdata, e.rdata);
                    check({e.name, " err"}, {31'b0, resp_err}, {31'b0, e.err});
                    check({e.name, " cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end else if (resp_err || resp_rdata != 32'd0) begin
                check("quiet resp", resp_rdata | {31'b0, resp_err}, 32'd0);
            end
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++;
                if (wq.size() == 0) begin
                    check("unexpected write", mem_addr, 32'hFFFFFFFF);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    check("wr addr", mem_addr, w.addr);
                    check("wr size", {30'b0, mem_size}, {30'b0, w.size});
                    check("wr data", mem_wdata, w.wdata);
                    check("wr cycle", 32'(cyc), 32'(w.cyc));
                end
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input string nm, input bit hold, output int t);
        int n;
        bit mis;
        req_is_load  = ld;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            check({nm, " accept timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis = (addr % n) != 0;
        rq.push_back('{exp_rd, exp_err,
                       t + (exp_err ? 1 : (mis ? n + 1 : 2)), nm});
        if (st && !exp_err) begin
            if (!mis)
                wq.push_back('{addr, f3[1:0], wd, t + 1});
            else
                for (int k = 0; k < n; k++)
                    wq.push_back('{addr + k, 2'b00,
                                   (wd >> (8 * k)) & 32'hFF, t + 1 + k});
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && rq.size() > 0; i++) @(negedge clk);
        if (rq.size() > 0) begin
            check({nm, " response timeout"}, 32'(rq.size()), 32'd0);
            rq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int t, t1, t2, rd0, wr0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h43] = 8'h5A;
        mem[10'h44] = 8'hA5;
        req_valid = 1'b0;
        req_is_load = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;

        #12;
        check("rst ready", {31'b0, req_ready}, 32'd1);
        check("rst resp", {30'b0, resp_valid, resp_err}, 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        check("rst strobes", {29'b0, mem_read, mem_write, |mem_size}, 32'd0);
        check("rst maddr", mem_addr | mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, "SW 10", 0, t);
        drain("SW 10");
        issue(1, 0, 3'd2, 32'h10, 0, 32'hDEADBEEF, 0, "LW 10", 0, t);
        drain("LW 10");
        issue(1, 0, 3'd0, 32'h11, 0, 32'hFFFFFFBE, 0, "LB 11", 0, t);
        drain("LB 11");
        issue(1, 0, 3'd4, 32'h11, 0, 32'h000000BE, 0, "LBU 11", 0, t);
        drain("LBU 11");
        issue(1, 0, 3'd1, 32'h12, 0, 32'hFFFFDEAD, 0, "LH 12", 0, t);
        drain("LH 12");
        issue(1, 0, 3'd5, 32'h12, 0, 32'h0000DEAD, 0, "LHU 12", 0, t);
        drain("LHU 12");

        issue(0, 1, 3'd2, 32'h21, 32'h11223344, 32'h0, 0, "SW 21", 0, t);
        drain("SW 21");
        issue(1, 0, 3'd2, 32'h21, 0, 32'h11223344, 0, "LW 21", 0, t);
        drain("LW 21");
        issue(1, 0, 3'd1, 32'h23, 0, 32'h00001122, 0, "LH 23", 0, t);
        drain("LH 23");

        rd0 = n_rd;
        wr0 = n_wr;
        issue(1, 0, 3'd1, 32'h3FF, 0, 32'h0, 1, "LH 3FF", 0, t);
        drain("LH 3FF");
        issue(1, 0, 3'd3, 32'h0, 0, 32'h0, 1, "L f3=3", 0, t);
        drain("L f3=3");
        issue(1, 1, 3'd2, 32'h0, 32'h1, 32'h0, 1, "LD+ST", 0, t);
        drain("LD+ST");
        issue(0, 1, 3'd4, 32'h0, 32'h1, 32'h0, 1, "S f3=4", 0, t);
        drain("S f3=4");
        issue(1, 0, 3'd2, 32'hFFFFFFFE, 0, 32'h0, 1, "LW top", 0, t);
        drain("LW top");
        check("err no reads", 32'(n_rd), 32'(rd0));
        check("err no writes", 32'(n_wr), 32'(wr0));

        issue(0, 1, 3'd2, 32'h41, 32'hAABBCCDD, 32'h0, 0, "SW 41", 0, t);
        for (int i = 0; i < 10 && cyc != t + 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("third byte cycle", 32'(cyc), 32'(t + 3));
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check("midrst mem", mem_addr | mem_wdata | {30'b0, mem_size}, 32'd0);
        check("midrst resp", {30'b0, resp_valid, resp_err}, 32'd0);
        check("midrst ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rq.delete();
        wq.delete();
        #1;
        check("post-rst ready", {31'b0, req_ready}, 32'd1);
        check("mem 41", {24'b0, mem[10'h41]}, 32'hDD);
        check("mem 42", {24'b0, mem[10'h42]}, 32'hCC);
        check("mem 43", {24'b0, mem[10'h43]}, 32'h5A);
        check("mem 44", {24'b0, mem[10'h44]}, 32'hA5);
        @(negedge clk);

        issue(1, 0, 3'd2, 32'h10, 0, 32'hDEADBEEF, 0, "b2b LW1", 1, t1);
        issue(1, 0, 3'd2, 32'h21, 0, 32'h11223344, 0, "b2b LW2", 0, t2);
        check("b2b accept gap", 32'(t2 - t1), 32'd3);
        drain("b2b");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
